hazard_stall_ctrl: RTL and testbench

//  Sequences the IF/ID pipeline register and PC. Generates pc_en, IF/ID write enable (ir_en),
//  IF/ID flush and ID/EX bubble. Sources: load-use hazards, multiply/divide busy, instruction

---
 rtl/hazard_stall_ctrl_pkg.sv | 15 +
 rtl/hazard_stall_ctrl_hazard_detect.sv | 34 +++
 rtl/hazard_stall_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the IF/ID stall controller.
//   state_e   : FSM state encoding (RUN/LD_STALL/MD_WAIT/IF_WAIT)
//   REG_ZERO  : architectural $zero register index; it never creates a load-use hazard
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MD_WAIT  = 2'd2,
    ST_IF_WAIT  = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational hazard detection for the instruction sitting in ID.
// Ports:
//   i_rs_id, i_rt_id       : source register fields of the ID instruction
//   i_use_rs_id/i_use_rt_id: which of those fields the ID instruction actually reads
//   i_memread_ex, i_rt_ex  : EX holds a load and its destination register
//   i_md_use_id, i_md_busy : ID needs the mult/div unit, and that unit is busy
//   o_ld_haz               : ID reads the register a load in EX is about to write
//   o_md_haz               : ID must wait for the mult/div unit
module hazard_stall_ctrl_hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [4:0] i_rs_id,
  input  logic [4:0] i_rt_id,
  input  logic       i_use_rs_id,
  input  logic       i_use_rt_id,
  input  logic       i_memread_ex,
  input  logic [4:0] i_rt_ex,
  input  logic       i_md_use_id,
  input  logic       i_md_busy,
  output logic       o_ld_haz,
  output logic       o_md_haz
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = i_use_rs_id && (i_rs_id == i_rt_ex);
  assign w_rt_match = i_use_rt_id && (i_rt_id == i_rt_ex);

  // A load into $zero is architecturally discarded, so nothing can depend on it.
  assign o_ld_haz = i_memread_ex && (i_rt_ex != REG_ZERO) && (w_rs_match || w_rt_match);
  assign o_md_haz = i_md_use_id && i_md_busy;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// IF/ID and PC sequencing: stalls the front end on load-use, mult/div busy and
// instruction-fetch wait, and flushes IF/ID on a taken branch.
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   rs_ID/rt_ID/use_*_ID  : operand fields of the ID instruction
//   memread_EX/rt_EX      : load in EX and its destination
//   md_use_ID/md_busy     : mult/div demand in ID and unit busy
//   imem_ready            : fetch data valid this cycle
//   branch_taken          : branch/jump resolved taken in ID
//   pc_en/ir_en           : PC and IF/ID write enables (always equal outside reset)
//   if_id_flush           : load a NOP into IF/ID at the next edge
//   id_ex_clr             : insert a bubble into ID/EX at the next edge
//   stall_cycles          : saturating count of cycles with ir_en=0
//   md_timeout            : sticky flag, mult/div wait reached MD_TIMEOUT cycles
//   o_dbg_state           : current FSM state, for observation only
// Handshake: none; all outputs are combinational from the registered state and
// the current-cycle inputs, and are forced low while reset is high.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic             memread_EX,
  input  logic [4:0]       rt_EX,
  input  logic             md_use_ID,
  input  logic             md_busy,
  input  logic             imem_ready,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ir_en,
  output logic             if_id_flush,
  output logic             id_ex_clr,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             md_timeout,
  output state_e           o_dbg_state
);

  localparam int                WC_W   = $clog2(MD_TIMEOUT + 1);
  localparam logic [WC_W-1:0]   WC_MAX = WC_W'(MD_TIMEOUT);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [WC_W-1:0]  w_wait_inc;
  logic             r_md_timeout;

  logic             w_ld_haz;
  logic             w_md_haz;
  logic             w_run_rules;
  logic             w_adv;        // pc_en == ir_en, so a single "advance" term
  logic             w_flush;
  logic             w_clr;

  hazard_stall_ctrl_hazard_detect u_hazard_detect (
    .i_rs_id      (rs_ID),
    .i_rt_id      (rt_ID),
    .i_use_rs_id  (use_rs_ID),
    .i_use_rt_id  (use_rt_ID),
    .i_memread_ex (memread_EX),
    .i_rt_ex      (rt_EX),
    .i_md_use_id  (md_use_ID),
    .i_md_busy    (md_busy),
    .o_ld_haz     (w_ld_haz),
    .o_md_haz     (w_md_haz)
  );

  // Next state and raw outputs. Wait states hold the pipe while their own
  // condition persists; once it clears they fall through to the RUN rules in
  // the same cycle, so no dead cycle is spent on leaving a stall. LD_STALL
  // only marks the cycle after a load-use stall: the load has left EX by then,
  // so the RUN rules apply directly (and a new load-use stalls again).
  always_comb begin
    w_state_next = r_state;
    w_run_rules  = 1'b1;
    w_adv        = 1'b1;
    w_flush      = 1'b0;
    w_clr        = 1'b0;

    case (r_state)
      ST_MD_WAIT: begin
        if (md_busy) begin
          w_run_rules = 1'b0;
          w_adv       = 1'b0;
          w_clr       = 1'b1;
        end
      end
      ST_IF_WAIT: begin
        if (!imem_ready) begin
          w_run_rules = 1'b0;
          w_adv       = 1'b0;
          w_clr       = 1'b1;
        end
      end
      default: ;
    endcase

    if (w_run_rules) begin
      if (w_md_haz) begin
        w_state_next = ST_MD_WAIT;
        w_adv        = 1'b0;
        w_clr        = 1'b1;
      end else if (w_ld_haz) begin
        w_state_next = ST_LD_STALL;
        w_adv        = 1'b0;
        w_clr        = 1'b1;
      end else if (!imem_ready) begin
        w_state_next = ST_IF_WAIT;
        w_adv        = 1'b0;
        w_clr        = 1'b1;
      end else begin
        // A taken branch only flushes when the pipe advances; a hazarded
        // branch is re-resolved by ID once the stall clears.
        w_state_next = ST_RUN;
        w_flush      = branch_taken;
      end
    end
  end

  // r_wait_cnt holds the 1-based index of the current MD_WAIT cycle, so the
  // timeout flag becomes visible during the MD_TIMEOUT-th wait cycle.
  assign w_wait_inc = (r_wait_cnt == WC_MAX) ? WC_MAX : r_wait_cnt + WC_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_stall_cnt  <= '0;
      r_wait_cnt   <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (!w_adv && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_state_next == ST_MD_WAIT) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc == WC_MAX) begin
          r_md_timeout <= 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign pc_en        = w_adv   && !reset;
  assign ir_en        = w_adv   && !reset;
  assign if_id_flush  = w_flush && !reset;
  assign id_ex_clr    = w_clr   && !reset;
  assign stall_cycles = r_stall_cnt;
  assign md_timeout   = r_md_timeout;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] rs_ID, rt_ID, rt_EX;
  logic       use_rs_ID, use_rt_ID, memread_EX, md_use_ID, md_busy, imem_ready, branch_taken;

  // u_dut: default parameters. u_sat: short timeout and 3-bit counter for boundaries.
  logic        pc_en, ir_en, if_id_flush, id_ex_clr, md_timeout;
  logic [15:0] stall_cycles;
  state_e      dbg_state;
  logic        pc_en2, ir_en2, if_id_flush2, id_ex_clr2, md_timeout2;
  logic [2:0]  stall_cycles2;
  state_e      dbg_state2;

  logic [3:0]  ctrl;
  assign ctrl = {pc_en, ir_en, if_id_flush, id_ex_clr};

  int n_vec  = 0;
  int n_miss = 0;

  hazard_stall_ctrl u_dut (
    .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID),
    .use_rt_ID(use_rt_ID), .memread_EX(memread_EX), .rt_EX(rt_EX), .md_use_ID(md_use_ID),
    .md_busy(md_busy), .imem_ready(imem_ready), .branch_taken(branch_taken),
    .pc_en(pc_en), .ir_en(ir_en), .if_id_flush(if_id_flush), .id_ex_clr(id_ex_clr),
    .stall_cycles(stall_cycles), .md_timeout(md_timeout), .o_dbg_state(dbg_state)
  );

  hazard_stall_ctrl #(.CNT_W(3), .MD_TIMEOUT(4)) u_sat (
    .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID),
    .use_rt_ID(use_rt_ID), .memread_EX(memread_EX), .rt_EX(rt_EX), .md_use_ID(md_use_ID),
    .md_busy(md_busy), .imem_ready(imem_ready), .branch_taken(branch_taken),
    .pc_en(pc_en2), .ir_en(ir_en2), .if_id_flush(if_id_flush2), .id_ex_clr(id_ex_clr2),
    .stall_cycles(stall_cycles2), .md_timeout(md_timeout2), .o_dbg_state(dbg_state2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rs_ID = 5'd0; rt_ID = 5'd0; rt_EX = 5'd0;
    use_rs_ID = 1'b0; use_rt_ID = 1'b0; memread_EX = 1'b0;
    md_use_ID = 1'b0; md_busy = 1'b0; imem_ready = 1'b1; branch_taken = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] dst, input logic [4:0] rs, input logic urs,
                            input logic [4:0] rt, input logic urt);
    memread_EX = 1'b1; rt_EX = dst;
    rs_ID = rs; use_rs_ID = urs; rt_ID = rt; use_rt_ID = urt;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    imem_ready = 1'b0;
    #3;
    if (ctrl !== 4'b0000) begin $display("FAIL reset ctrl: got %b want 0000", ctrl); n_miss++; end
    n_vec++;
    if (stall_cycles !== 16'd0 || md_timeout !== 1'b0 || dbg_state !== ST_RUN) begin
      $display("FAIL reset regs: cnt=%0d to=%b st=%0d want 0/0/0", stall_cycles, md_timeout, dbg_state);
      n_miss++;
    end
    n_vec++;
    repeat (3) next_cycle();
    if (stall_cycles !== 16'd0) begin $display("FAIL reset no count: got %0d want 0", stall_cycles); n_miss++; end
    n_vec++;
    reset = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    if (ctrl !== 4'b1100) begin $display("FAIL reset release ctrl: got %b want 1100", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive_load(5'd8, 5'd8, 1'b1, 5'd3, 1'b0);
    @(negedge clk);
    if (ctrl !== 4'b0001) begin $display("FAIL ld rs stall: got %b want 0001", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    drive_idle();
    @(negedge clk);
    if (ctrl !== 4'b1100 || dbg_state !== ST_LD_STALL) begin
      $display("FAIL ld resume: ctrl=%b st=%0d want 1100/1", ctrl, dbg_state); n_miss++;
    end
    n_vec++;
    next_cycle();
    if (stall_cycles !== 16'd1 || dbg_state !== ST_RUN) begin
      $display("FAIL ld count: cnt=%0d st=%0d want 1/0", stall_cycles, dbg_state); n_miss++;
    end
    n_vec++;
    // rt-side match, matching rs field that is not read, and a different register
    drive_load(5'd9, 5'd9, 1'b0, 5'd9, 1'b1);
    @(negedge clk);
    if (ctrl !== 4'b0001) begin $display("FAIL ld rt stall: got %b want 0001", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    drive_load(5'd9, 5'd9, 1'b0, 5'd4, 1'b1);
    @(negedge clk);
    if (ctrl !== 4'b1100) begin $display("FAIL ld unused match: got %b want 1100", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    if (ctrl !== 4'b0001) begin $display("FAIL b2b first: got %b want 0001", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    drive_load(5'd6, 5'd1, 1'b1, 5'd6, 1'b1);
    @(negedge clk);
    if (ctrl !== 4'b0001) begin $display("FAIL b2b second: got %b want 0001", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    drive_idle();
    @(negedge clk);
    if (ctrl !== 4'b1100) begin $display("FAIL b2b resume: got %b want 1100", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    if (stall_cycles !== 16'd2) begin $display("FAIL b2b count: got %0d want 2", stall_cycles); n_miss++; end
    n_vec++;
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    @(negedge clk);
    if (ctrl !== 4'b1100) begin $display("FAIL zero reg ctrl: got %b want 1100", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    if (dbg_state !== ST_RUN || stall_cycles !== 16'd0) begin
      $display("FAIL zero reg state: st=%0d cnt=%0d want 0/0", dbg_state, stall_cycles); n_miss++;
    end
    n_vec++;
    drive_idle();
  endtask

  task automatic test_md_wait();
    do_reset();
    md_use_ID = 1'b1;
    md_busy   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ctrl !== 4'b0001) begin $display("FAIL md wait cyc%0d: got %b want 0001", i, ctrl); n_miss++; end
      n_vec++;
      next_cycle();
    end
    md_busy = 1'b0;
    @(negedge clk);
    if (ctrl !== 4'b1100) begin $display("FAIL md resume: got %b want 1100", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    if (stall_cycles !== 16'd5 || md_timeout !== 1'b0 || dbg_state !== ST_RUN) begin
      $display("FAIL md end: cnt=%0d to=%b st=%0d want 5/0/0", stall_cycles, md_timeout, dbg_state);
      n_miss++;
    end
    n_vec++;
    drive_idle();
  endtask

  task automatic test_md_timeout();
    do_reset();
    md_use_ID = 1'b1;
    md_busy   = 1'b1;
    // Cycle 0 detects the hazard in RUN; cycles 1..9 are MD_WAIT cycles 1..9.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (md_timeout2 !== (i >= 4)) begin
        $display("FAIL md timeout cyc%0d: got %b want %b", i, md_timeout2, (i >= 4)); n_miss++;
      end
      n_vec++;
      next_cycle();
    end
    md_busy = 1'b0;
    @(negedge clk);
    if ({pc_en2, ir_en2, if_id_flush2, id_ex_clr2} !== 4'b1100 || md_timeout !== 1'b0) begin
      $display("FAIL md timeout resume: ctrl=%b to=%b want 1100/0",
               {pc_en2, ir_en2, if_id_flush2, id_ex_clr2}, md_timeout); n_miss++;
    end
    n_vec++;
    next_cycle();
    drive_idle();
    repeat (3) next_cycle();
    if (md_timeout2 !== 1'b1 || stall_cycles2 !== 3'd7 || stall_cycles !== 16'd10) begin
      $display("FAIL md sticky/sat: to=%b sat=%0d cnt=%0d want 1/7/10", md_timeout2, stall_cycles2, stall_cycles);
      n_miss++;
    end
    n_vec++;
    do_reset();
    if (md_timeout2 !== 1'b0) begin $display("FAIL md timeout clear: got %b want 0", md_timeout2); n_miss++; end
    n_vec++;
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1'b1;
    drive_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    if (ctrl !== 4'b0001) begin $display("FAIL br hazarded: got %b want 0001", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    drive_idle();
    branch_taken = 1'b1;
    @(negedge clk);
    if (ctrl !== 4'b1110) begin $display("FAIL br flush: got %b want 1110", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    imem_ready = 1'b0;
    @(negedge clk);
    if (ctrl !== 4'b0001) begin $display("FAIL br imem wait: got %b want 0001", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    drive_idle();
    @(negedge clk);
    if (ctrl !== 4'b1100) begin $display("FAIL br idle: got %b want 1100", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
  endtask

  task automatic test_priority();
    do_reset();
    md_use_ID = 1'b1; md_busy = 1'b1; imem_ready = 1'b0;
    drive_load(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    next_cycle();
    if (dbg_state !== ST_MD_WAIT) begin $display("FAIL prio md: st=%0d want 2", dbg_state); n_miss++; end
    n_vec++;
    md_busy = 1'b0;
    @(negedge clk);
    if (ctrl !== 4'b0001) begin $display("FAIL prio md exit ld: got %b want 0001", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    if (dbg_state !== ST_LD_STALL) begin $display("FAIL prio ld: st=%0d want 1", dbg_state); n_miss++; end
    n_vec++;
    memread_EX = 1'b0;
    next_cycle();
    if (dbg_state !== ST_IF_WAIT) begin $display("FAIL prio if: st=%0d want 3", dbg_state); n_miss++; end
    n_vec++;
    drive_idle();
    next_cycle();
    if (dbg_state !== ST_RUN || stall_cycles !== 16'd3) begin
      $display("FAIL prio end: st=%0d cnt=%0d want 0/3", dbg_state, stall_cycles); n_miss++;
    end
    n_vec++;
  endtask

  task automatic test_if_wait_reset();
    do_reset();
    imem_ready = 1'b0;
    @(negedge clk);
    if (ctrl !== 4'b0001) begin $display("FAIL ifw cyc1: got %b want 0001", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    #1 reset = 1'b1;
    #1;
    if (ctrl !== 4'b0000 || stall_cycles !== 16'd0 || dbg_state !== ST_RUN) begin
      $display("FAIL ifw async reset: ctrl=%b cnt=%0d st=%0d want 0000/0/0", ctrl, stall_cycles, dbg_state);
      n_miss++;
    end
    n_vec++;
    #1 reset = 1'b0;
    @(negedge clk);
    if (ctrl !== 4'b0001) begin $display("FAIL ifw after reset: got %b want 0001", ctrl); n_miss++; end
    n_vec++;
    next_cycle();
    @(negedge clk);
    if (ctrl !== 4'b0001 || dbg_state !== ST_IF_WAIT) begin
      $display("FAIL ifw cyc3: ctrl=%b st=%0d want 0001/3", ctrl, dbg_state); n_miss++;
    end
    n_vec++;
    next_cycle();
    imem_ready = 1'b1;
    @(negedge clk);
    if (ctrl !== 4'b1100 || stall_cycles !== 16'd2) begin
      $display("FAIL ifw resume: ctrl=%b cnt=%0d want 1100/2", ctrl, stall_cycles); n_miss++;
    end
    n_vec++;
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_zero_reg();
    test_md_wait();
    test_md_timeout();
    test_branch();
    test_priority();
    test_if_wait_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
